// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU.
//   alu_op_e    : 3-bit opcode; every encoding is a defined operation.
//   alu_flags_t : flag bundle carried alongside a result (zero, carry, error).
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic error;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_exec.sv
// Combinational ALU core for alu_pipe.
//   a, b   : operands; for shifts b[$clog2(WIDTH)-1:0] is the shift amount
//   op     : opcode
//   result : WIDTH-bit result (0 on error)
//   flags  : zero (result==0 and no error), carry/borrow/shifted-out bit,
//            error (shift amount has bits set above the legal range)
module alu_pipe_exec
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  sh;
  logic             shift_oor;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic             err;

  assign sh        = b[SH_W-1:0];
  assign shift_oor = |b[WIDTH-1:SH_W];

  always_comb begin
    wide = '0;
    res  = '0;
    cy   = 1'b0;
    err  = 1'b0;
    unique case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[WIDTH-1:0];
        cy   = wide[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow (a < b).
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[WIDTH-1:0];
        cy   = wide[WIDTH];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: begin
        if (shift_oor) begin
          err = 1'b1;
        end else begin
          // Extra MSB catches a[WIDTH-sh]; stays 0 when sh==0.
          wide = {1'b0, a} << sh;
          res  = wide[WIDTH-1:0];
          cy   = wide[WIDTH];
        end
      end
      OP_SHR: begin
        if (shift_oor) begin
          err = 1'b1;
        end else begin
          // Extra LSB catches a[sh-1]; stays 0 when sh==0.
          wide = {a, 1'b0} >> sh;
          res  = wide[WIDTH:1];
          cy   = wide[0];
        end
      end
      OP_CMP: res = {{(WIDTH-1){1'b0}}, (a < b)};
    endcase
  end

  assign result      = res;
  assign flags.zero  = (res == '0) & ~err;
  assign flags.carry = cy;
  assign flags.error = err;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and full backpressure.
//   clk, rst                : clock (rising edge), async active-high reset
//   in_valid_i / in_ready_o : operand beat handshake (a_i, b_i, op_i)
//   out_valid_o/out_ready_i : result beat handshake
//   result_o, zero_o, carry_o, error_o : registered result and flags
//   op_count_o  : completed output beats, saturating
//   err_count_o : completed output beats with error_o set, saturating
// S1 registers operands; S2 registers the computed result. Both stages may
// advance on the same edge, giving one beat per cycle when unstalled.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             error_o,
  output logic [CNT_W-1:0] op_count_o,
  output logic [CNT_W-1:0] err_count_o
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  alu_flags_t       s2_flags;

  logic [WIDTH-1:0] exec_result;
  alu_flags_t       exec_flags;

  logic s2_load;
  logic in_fire;
  logic out_fire;

  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] err_count;

  // S2 accepts when empty or when its current beat leaves this edge.
  assign s2_load    = s1_valid & (~s2_valid | out_ready_i);
  assign in_ready_o = ~s1_valid | s2_load;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = s2_valid & out_ready_i;

  alu_pipe_exec #(.WIDTH(WIDTH)) u_exec (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (exec_result),
    .flags  (exec_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a_i;
      s1_b     <= b_i;
      s1_op    <= alu_op_e'(op_i);
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_result <= exec_result;
      s2_flags  <= exec_flags;
    end else if (out_fire) begin
      s2_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (out_fire) begin
      if (op_count != '1) begin
        op_count <= op_count + CNT_W'(1);
      end
      if (s2_flags.error && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  assign out_valid_o = s2_valid;
  assign result_o    = s2_result;
  assign zero_o      = s2_flags.zero;
  assign carry_o     = s2_flags.carry;
  assign error_o     = s2_flags.error;
  assign op_count_o  = op_count;
  assign err_count_o = err_count;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8). A scoreboard queue receives the
// expected result when a beat is accepted and is popped when a result beat
// transfers. A second instance with CNT_W=2 exercises counter saturation.
module tb_alu_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  a, b, result;
  logic [2:0]    op;
  logic          zero, carry, error;
  logic [CW-1:0] op_count, err_count;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [W-1:0]  s_result;
  logic          s_zero, s_carry, s_error;
  logic [1:0]    s_op_count, s_err_count;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .op_i(op),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .zero_o(zero), .carry_o(carry), .error_o(error),
    .op_count_o(op_count), .err_count_o(err_count)
  );

  alu_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
    .a_i(a), .b_i(b), .op_i(op),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
    .result_o(s_result), .zero_o(s_zero), .carry_o(s_carry), .error_o(s_error),
    .op_count_o(s_op_count), .err_count_o(s_err_count)
  );

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         error;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  exp_t        sb[$];
  exp_t        next_exp;
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned exp_ops = 0;
  int unsigned exp_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference model written in integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
    exp_t        e;
    int unsigned xi, yi, sh, r, m;
    logic        c;
    xi = int'(x);
    yi = int'(y);
    sh = yi % W;
    m  = 1 << W;
    r  = 0;
    c  = 1'b0;
    e  = '0;
    if ((o == 3'd5 || o == 3'd6) && yi >= W) begin
      e.error = 1'b1;
      return e;
    end
    case (o)
      3'd0: begin r = xi + yi; c = (r >= m); r = r % m; end
      3'd1: begin c = (xi < yi); r = (xi + m - yi) % m; end
      3'd2: r = xi & yi;
      3'd3: r = xi | yi;
      3'd4: r = xi ^ yi;
      3'd5: begin r = xi * (1 << sh); c = (sh != 0) && (((r >> W) & 1) == 1); r = r % m; end
      3'd6: begin r = xi / (1 << sh); c = (sh != 0) && (((xi >> (sh - 1)) & 1) == 1); end
      default: r = (xi < yi) ? 1 : 0;
    endcase
    e.result = r[W-1:0];
    e.carry  = c;
    e.zero   = (r == 0);
    return e;
  endfunction

  function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] r, input logic z, input logic c, input logic er);
    vec_t v;
    v.op = o; v.a = x; v.b = y;
    v.e  = {r, z, c, er};
    return v;
  endfunction

  // Scoreboard: pop/compare on output transfer, push on input transfer.
  always @(negedge clk) begin : monitor
    exp_t got;
    if (!rst && out_valid && out_ready) begin
      got = {result, zero, carry, error};
      if (sb.size() == 0) check("unexpected_output", out_valid, 1'b0);
      else check("result_beat", got, sb.pop_front());
    end
    if (!rst && in_valid && in_ready) sb.push_back(next_exp);
  end

  // Present one beat from posedge+1 and hold it until accepted.
  task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e, output int unsigned waits);
    in_valid = 1'b1; op = o; a = x; b = y; next_exp = e;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    else begin
      exp_ops++;
      if (e.error) exp_errs++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [20];
    vec_t        v;
    exp_t        e;
    exp_t        e0;
    int unsigned w;
    int unsigned stalls;
    logic [2:0]  ro;
    logic [W-1:0] ra, rb;

    tbl[0]  = mk(3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0);
    tbl[1]  = mk(3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(3'd4, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(3'd5, 8'h81, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(3'd6, 8'h03, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(3'd5, 8'h02, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0);
    tbl[10] = mk(3'd6, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(3'd6, 8'h40, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(3'd5, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(3'd5, 8'h55, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[14] = mk(3'd6, 8'hFF, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
    tbl[15] = mk(3'd7, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(3'd7, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk(3'd7, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    tbl[18] = mk(3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    tbl[19] = mk(3'd2, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);

    in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b1; next_exp = '0;

    // Power-on reset
    repeat (3) @(negedge clk);
    check("rst_outputs", {out_valid, result, zero, carry, error, op_count, err_count}, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // Latency: result visible after the edge following acceptance
    drive(3'd0, 8'hF0, 8'h20, {8'h10, 1'b0, 1'b1, 1'b0}, w);
    check("latency_edge1", out_valid, 1'b0);
    @(posedge clk); #1;
    check("latency_edge2", out_valid, 1'b1);

    // Directed vectors, streamed back to back
    for (int i = 0; i < 20; i++) begin
      v = tbl[i];
      drive(v.op, v.a, v.b, v.e, w);
    end
    drain();
    check("op_count_table", op_count, 64'(exp_ops));
    check("err_count_table", err_count, 64'(exp_errs));
    check("err_count_two", err_count, 2);

    // Backpressure: two beats fill the pipe, third must wait
    out_ready = 1'b0;
    e0 = {8'h03, 1'b0, 1'b0, 1'b0};
    drive(3'd0, 8'h01, 8'h02, e0, w);
    check("bp_accept0", w, 0);
    e = {8'h0C, 1'b0, 1'b0, 1'b0};
    drive(3'd3, 8'h08, 8'h04, e, w);
    check("bp_accept1", w, 0);
    e = {8'h04, 1'b0, 1'b0, 1'b0};
    in_valid = 1'b1; op = 3'd1; a = 8'h07; b = 8'h03; next_exp = e;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_hold", {out_valid, result, zero, carry, error}, {1'b1, e0});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(3'd1, 8'h07, 8'h03, e, w);
    e = {8'h01, 1'b0, 1'b0, 1'b0};
    drive(3'd7, 8'h00, 8'hFF, e, w);
    drain();
    check("op_count_bp", op_count, 64'(exp_ops));

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(3'd0, 8'h11, 8'h22, model(8'h11, 8'h22, 3'd0), w);
    drive(3'd4, 8'h33, 8'h0F, model(8'h33, 8'h0F, 3'd4), w);
    #2 rst = 1'b1;
    sb.delete();
    exp_ops = 0;
    exp_errs = 0;
    @(negedge clk);
    check("midrst_outputs", {out_valid, result, zero, carry, error, op_count, err_count}, '0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_output", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Full rate random stream
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      if ((ro == 3'd5 || ro == 3'd6) && $urandom_range(0, 3) != 0) rb = 8'($urandom_range(0, 7));
      else rb = 8'($urandom_range(0, 255));
      drive(ro, ra, rb, model(ra, rb, ro), w);
      stalls += w;
    end
    drain();
    check("full_rate_stalls", stalls, 0);
    check("op_count_100", op_count, 100);
    check("err_count_rand", err_count, 64'(exp_errs));

    // Counter saturation on the CNT_W=2 instance (all beats are errors)
    a = 8'h55; b = 8'h09; op = 3'd5;
    s_in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("sat_in_ready", s_in_ready, 1'b1);
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_op_count", s_op_count, 3);
    check("sat_err_count", s_err_count, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
